uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmit engine for the serial TX path. It merges the frame FSM, bit serializer, parity generator and output mux into one block. It generalises the fixed-frame TX controller with configurable data width, runtime-selectable odd/even parity, one or two stop bits, an internal bit counter (no external `ser_done`), and back-to-back frame acceptance without an idle gap. It sits between the TX data source (FIFO/synchroniser) and the `TX_OUT` pin, and emits one bit per `CLK` cycle; `CLK` is the baud-tick clock.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame. Legal range is 5..9.
- `CLK` input 1: baud clock. All logic is on its rising edge.
- `RST` input 1: reset, synchronous and active-low. It is sampled on the rising edge of `CLK`.
- `P_DATA` input `DATA_WIDTH`: parallel payload. It is latched on accept.
- `Data_valid` input 1: frame request. A frame is accepted when `Data_valid && tx_ready` at a rising edge.
- `PAR_EN` input 1: 1 inserts a parity bit. It is latched on accept.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd parity. It is latched on accept.
- `STOP2` input 1: 1 selects two stop bits, 0 selects one. It is latched on accept.
- `TX_OUT` output 1: serial line, registered. It idles high.
- `busy` output 1: high in every non-IDLE state.
- `tx_ready` output 1: high in IDLE and during the final stop-bit cycle.
- `frame_done` output 1: one-cycle pulse during the final stop-bit cycle.

## Operation
- States are IDLE, START, DATA, PARITY, STOP. An internal counter tracks the bit index in DATA and the stop index in STOP.
- **IDLE:** `TX_OUT`=1, `busy`=0, `tx_ready`=1.
  - On accept, latch `P_DATA`, `PAR_EN`, `PAR_TYP`, `STOP2` into a shadow register, then go to START.
- **START:** `TX_OUT`=0, lasting 1 cycle, then go to DATA with the counter at 0.
- **DATA:** `TX_OUT` = shadow data[counter], sent LSB first, for exactly `DATA_WIDTH` cycles.
  - After the cycle with counter = `DATA_WIDTH`-1: go to PARITY if latched `PAR_EN`=1, otherwise go to STOP.
- **PARITY:** `TX_OUT` = (XOR of the latched payload) XOR latched `PAR_TYP`, lasting 1 cycle, then go to STOP.
- **STOP:** `TX_OUT`=1 for 1 cycle, or 2 cycles if latched `STOP2`=1.
  - In the final stop cycle, `tx_ready`=1 and `frame_done`=1.
  - Exiting the final stop cycle: go to START if an accept occurs on that edge (back-to-back, new operands latched), otherwise go to IDLE.
- `Data_valid` while `tx_ready`=0 is ignored. Nothing is queued and nothing is reported.
- Input changes on `P_DATA`, `PAR_EN`, `PAR_TYP` or `STOP2` mid-frame have no effect on the frame in flight.
- Frame length in cycles = 1 + `DATA_WIDTH` + `PAR_EN` + (1 + `STOP2`). With `DATA_WIDTH`=8, the range is 10..12.
- Counter width is ceil(log2(`DATA_WIDTH`)). The counter must not wrap inside DATA.

## Timing
- Reset values: `TX_OUT`=1, `busy`=0, `tx_ready`=1, `frame_done`=0, state IDLE, counter 0, shadow register 0.
- Reset asserted mid-frame aborts the frame. On the next edge, `TX_OUT`=1 and IDLE. No `frame_done` is emitted.
- Accept at edge k:
  - `TX_OUT`=0 and `busy`=1 from edge k to edge k+1.
  - The first data bit appears after edge k+1.
- `TX_OUT`, `busy`, `tx_ready` and `frame_done` are all flop outputs, so they are glitch-free. Each is a function of the state after the edge.
- Back-to-back: the final stop bit of frame N is immediately followed by the start bit of frame N+1. `busy` stays 1 throughout and no idle cycle is inserted.
- Reset and `Data_valid` on the same edge: reset wins, and the request is dropped.

## Test plan
- **Even parity, one stop bit:** `DATA_WIDTH`=8, `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, `STOP2`=0.
  - Required `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles).
  - `busy` is high for 11 cycles. `frame_done` pulses on cycle 11, then IDLE.
- **Odd parity, two stop bits:** same payload, `PAR_TYP`=1, `STOP2`=1.
  - Parity bit = 1. Frame is 12 cycles ending 1,1,1 (parity, stop, stop).
  - `tx_ready` is low on the first stop cycle and high on the second.
- **No parity, two stop bits:** `P_DATA`=0x3C, `PAR_EN`=0, `STOP2`=1.
  - Required `TX_OUT` = 0,0,0,1,1,1,1,0,0,1,1 (11 cycles). No parity slot.
- **Back-to-back:** hold `Data_valid`=1 for 0x55 then 0xFF with `PAR_EN`=0.
  - The second start bit immediately follows the first stop bit.
  - `busy` never drops. `frame_done` pulses twice, 10 cycles apart.
- **Ignored request and mid-frame changes:** pulse `Data_valid` with `P_DATA`=0x00 during DATA of a 0xA5 frame, and toggle `PAR_TYP` at the same time.
  - The 0xA5 frame is unchanged. No second frame is sent.
- **Reset mid-frame, then narrow width:** assert `RST`=0 during DATA.
  - `TX_OUT`=1, `busy`=0, `tx_ready`=1 after the next edge, with no `frame_done`.
  - Then, with the `DATA_WIDTH`=5 instance, send `P_DATA`=5'h13 with even parity, one stop bit.
  - Required `TX_OUT` = 0,1,1,0,0,1,1,1 (8 cycles).

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Parametrised UART transmit engine. One serial bit is emitted per rising
// edge of CLK, which is the baud tick. The frame is a start bit, DATA_WIDTH
// payload bits sent LSB first, an optional parity bit, and one or two stop
// bits. A new frame may be accepted in the final stop cycle, so frames can
// run back to back without an idle gap.
//
// Ports:
//   CLK        : baud clock, all logic on its rising edge
//   RST        : synchronous active-low reset
//   P_DATA     : parallel payload, latched on accept
//   Data_valid : frame request, accepted when Data_valid && tx_ready
//   PAR_EN     : 1 inserts a parity bit (latched on accept)
//   PAR_TYP    : 0 even parity, 1 odd parity (latched on accept)
//   STOP2      : 1 selects two stop bits (latched on accept)
//   TX_OUT     : registered serial line, idles high
//   busy       : high in every state other than IDLE
//   tx_ready   : high in IDLE and in the final stop cycle
//   frame_done : one-cycle pulse in the final stop cycle
module uart_tx_param #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  tx_ready,
   output logic                  frame_done
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] sh_data, sh_data_nx;
   logic                  sh_par_en, sh_par_en_nx;
   logic                  sh_par_typ, sh_par_typ_nx;
   logic                  sh_stop2, sh_stop2_nx;
   logic                  tx_out_nx, busy_nx, tx_ready_nx, frame_done_nx;
   logic                  accept;
   logic                  stop_last;
   logic                  stop_last_nx;
   logic                  data_bit_nx;

   // Next-state and next-output decode. The counter holds the bit index in
   // DATA and the stop index in STOP. The outputs are decoded from the state
   // the machine is about to enter, so once registered they describe the
   // state after the edge and never glitch. tx_ready is itself a flop, so
   // the accept condition only depends on registered values and Data_valid.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      sh_data_nx    = sh_data;
      sh_par_en_nx  = sh_par_en;
      sh_par_typ_nx = sh_par_typ;
      sh_stop2_nx   = sh_stop2;
      tx_out_nx     = 1'b1;
      busy_nx       = 1'b0;
      tx_ready_nx   = 1'b0;
      frame_done_nx = 1'b0;
      data_bit_nx   = 1'b0;

      accept    = Data_valid && tx_ready;
      stop_last = (cnt == {{(CW-1){1'b0}}, sh_stop2});

      if (accept) begin
         sh_data_nx    = P_DATA;
         sh_par_en_nx  = PAR_EN;
         sh_par_typ_nx = PAR_TYP;
         sh_stop2_nx   = STOP2;
      end

      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = START;
            end
         end
         START: begin
            state_nx = DATA;
            cnt_nx   = '0;
         end
         DATA: begin
            if (cnt == LAST_BIT) begin
               state_nx = sh_par_en ? PARITY : STOP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         PARITY: begin
            state_nx = STOP;
            cnt_nx   = '0;
         end
         STOP: begin
            if (stop_last) begin
               state_nx = accept ? START : IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (cnt_nx == CW'(i)) begin
            data_bit_nx = sh_data_nx[i];
         end
      end

      stop_last_nx = (cnt_nx == {{(CW-1){1'b0}}, sh_stop2_nx});
      busy_nx      = (state_nx != IDLE);

      unique case (state_nx)
         IDLE: begin
            tx_out_nx   = 1'b1;
            tx_ready_nx = 1'b1;
         end
         START: begin
            tx_out_nx = 1'b0;
         end
         DATA: begin
            tx_out_nx = data_bit_nx;
         end
         PARITY: begin
            tx_out_nx = (^sh_data_nx) ^ sh_par_typ_nx;
         end
         STOP: begin
            tx_out_nx     = 1'b1;
            tx_ready_nx   = stop_last_nx;
            frame_done_nx = stop_last_nx;
         end
         default: begin
            tx_out_nx   = 1'b1;
            tx_ready_nx = 1'b1;
         end
      endcase
   end

   // State, counter, shadow operands and all four outputs are registered
   // here. Reset is synchronous, so a reset edge that coincides with a
   // request simply drops the request.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         cnt        <= '0;
         sh_data    <= '0;
         sh_par_en  <= 1'b0;
         sh_par_typ <= 1'b0;
         sh_stop2   <= 1'b0;
         TX_OUT     <= 1'b1;
         busy       <= 1'b0;
         tx_ready   <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         sh_data    <= sh_data_nx;
         sh_par_en  <= sh_par_en_nx;
         sh_par_typ <= sh_par_typ_nx;
         sh_stop2   <= sh_stop2_nx;
         TX_OUT     <= tx_out_nx;
         busy       <= busy_nx;
         tx_ready   <= tx_ready_nx;
         frame_done <= frame_done_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
// Bench for uart_tx_param. An 8-bit instance carries the table-driven frames
// and the back-to-back, ignored-request and reset corner cases; a 5-bit
// instance checks the narrow payload width. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_uart_tx_param;

   logic       CLK_tb;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       STOP2;
   logic       TX_OUT;
   logic       busy;
   logic       tx_ready;
   logic       frame_done;

   logic [4:0] P_DATA5;
   logic       Data_valid5;
   logic       TX_OUT5;
   logic       busy5;
   logic       tx_ready5;
   logic       frame_done5;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [7:0]  p_data;
      logic        par_en;
      logic        par_typ;
      logic        stop2;
      int          len;
      logic [0:11] bits;
   } vec_t;

   vec_t vecs [4];

   uart_tx_param #(.DATA_WIDTH(8)) dut8 (
      .CLK        (CLK_tb),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_valid (Data_valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .tx_ready   (tx_ready),
      .frame_done (frame_done)
   );

   uart_tx_param #(.DATA_WIDTH(5)) dut5 (
      .CLK        (CLK_tb),
      .RST        (RST),
      .P_DATA     (P_DATA5),
      .Data_valid (Data_valid5),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .TX_OUT     (TX_OUT5),
      .busy       (busy5),
      .tx_ready   (tx_ready5),
      .frame_done (frame_done5)
   );

   // Free-running baud clock, 10 time units per bit.
   initial begin
      CLK_tb = 1'b0;
      forever #5 CLK_tb = ~CLK_tb;
   end

   // Hard time limit so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0b, required %0b", name, actual, expected);
      end
   endtask

   task automatic checkCycle(input string name, input int i,
                             input logic a_tx, input logic a_busy,
                             input logic a_rdy, input logic a_done,
                             input logic e_tx, input logic e_busy,
                             input logic e_rdy, input logic e_done);
      checkOutput($sformatf("%s c%0d TX_OUT", name, i), a_tx, e_tx);
      checkOutput($sformatf("%s c%0d busy", name, i), a_busy, e_busy);
      checkOutput($sformatf("%s c%0d tx_ready", name, i), a_rdy, e_rdy);
      checkOutput($sformatf("%s c%0d frame_done", name, i), a_done, e_done);
   endtask

   // Presents a request to the 8-bit instance; accepted on the next rising edge.
   task automatic applyStimulus(input logic [7:0] d, input logic pe,
                                input logic pt, input logic s2);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      STOP2      = s2;
      Data_valid = 1'b1;
   endtask

   task automatic runFrame(input vec_t v, input string name);
      applyStimulus(v.p_data, v.par_en, v.par_typ, v.stop2);
      for (int i = 0; i < v.len; i++) begin
         @(negedge CLK_tb);
         if (i == 0) Data_valid = 1'b0;
         checkCycle(name, i, TX_OUT, busy, tx_ready, frame_done,
                    v.bits[i], 1'b1, (i == v.len - 1), (i == v.len - 1));
      end
      @(negedge CLK_tb);
      checkCycle(name, v.len, TX_OUT, busy, tx_ready, frame_done,
                 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   logic [0:19] b2b_bits;
   logic [0:7]  narrow_bits;

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      RST         = 1'b0;
      P_DATA      = '0;
      Data_valid  = 1'b0;
      PAR_EN      = 1'b0;
      PAR_TYP     = 1'b0;
      STOP2       = 1'b0;
      P_DATA5     = '0;
      Data_valid5 = 1'b0;

      // Frames listed cycle by cycle from the accept edge: start, data LSB
      // first, optional parity, stop bit(s). Unused trailing slots are 0.
      vecs[0] = '{p_data: 8'hA5, par_en: 1'b1, par_typ: 1'b0, stop2: 1'b0,
                  len: 11, bits: 12'b0101_0010_1010};
      vecs[1] = '{p_data: 8'hA5, par_en: 1'b1, par_typ: 1'b1, stop2: 1'b1,
                  len: 12, bits: 12'b0101_0010_1111};
      vecs[2] = '{p_data: 8'h3C, par_en: 1'b0, par_typ: 1'b0, stop2: 1'b1,
                  len: 11, bits: 12'b0001_1110_0110};
      vecs[3] = '{p_data: 8'hFF, par_en: 1'b1, par_typ: 1'b1, stop2: 1'b0,
                  len: 11, bits: 12'b0111_1111_1110};
      b2b_bits    = 20'b0101010101_0111111111;
      narrow_bits = 8'b0110_0111;

      // Reset state of both instances.
      repeat (2) @(negedge CLK_tb);
      checkCycle("reset w8", 0, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);
      checkCycle("reset w5", 0, TX_OUT5, busy5, tx_ready5, frame_done5, 1'b1, 1'b0, 1'b1, 1'b0);
      RST = 1'b1;
      @(negedge CLK_tb);

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         runFrame(vecs[v], $sformatf("vec%0d", v));
      end

      // Back-to-back: Data_valid held through the first final stop cycle.
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK_tb);
         if (i == 0) P_DATA = 8'hFF;
         if (i == 10) Data_valid = 1'b0;
         checkCycle("b2b", i, TX_OUT, busy, tx_ready, frame_done,
                    b2b_bits[i], 1'b1, (i == 9 || i == 19), (i == 9 || i == 19));
      end
      @(negedge CLK_tb);
      checkCycle("b2b", 20, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);

      // Request and operand changes during DATA must not disturb the frame.
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         @(negedge CLK_tb);
         if (i == 0) Data_valid = 1'b0;
         if (i == 3) begin
            Data_valid = 1'b1;
            P_DATA     = 8'h00;
            PAR_TYP    = 1'b1;
         end
         if (i == 4) Data_valid = 1'b0;
         checkCycle("ignored", i, TX_OUT, busy, tx_ready, frame_done,
                    vecs[0].bits[i], 1'b1, (i == 10), (i == 10));
      end
      for (int i = 11; i < 13; i++) begin
         @(negedge CLK_tb);
         checkCycle("ignored", i, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      PAR_TYP = 1'b0;

      // Reset asserted during DATA aborts the frame without frame_done.
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK_tb);
         if (i == 0) Data_valid = 1'b0;
         checkOutput($sformatf("abort c%0d TX_OUT", i), TX_OUT, vecs[0].bits[i]);
      end
      RST = 1'b0;
      @(negedge CLK_tb);
      checkCycle("abort", 5, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);
      RST = 1'b1;
      for (int i = 6; i < 9; i++) begin
         @(negedge CLK_tb);
         checkCycle("abort", i, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);
      end

      // Reset and a request on the same edge: the request is dropped.
      RST        = 1'b0;
      P_DATA     = 8'h3C;
      Data_valid = 1'b1;
      @(negedge CLK_tb);
      RST        = 1'b1;
      Data_valid = 1'b0;
      checkCycle("rst+req", 0, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge CLK_tb);
      checkCycle("rst+req", 1, TX_OUT, busy, tx_ready, frame_done, 1'b1, 1'b0, 1'b1, 1'b0);

      // Narrow 5-bit instance: 5'h13, even parity, one stop bit.
      P_DATA5     = 5'h13;
      PAR_EN      = 1'b1;
      PAR_TYP     = 1'b0;
      STOP2       = 1'b0;
      Data_valid5 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK_tb);
         if (i == 0) Data_valid5 = 1'b0;
         checkCycle("w5", i, TX_OUT5, busy5, tx_ready5, frame_done5,
                    narrow_bits[i], 1'b1, (i == 7), (i == 7));
      end
      @(negedge CLK_tb);
      checkCycle("w5", 8, TX_OUT5, busy5, tx_ready5, frame_done5, 1'b1, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
